// File: rtl/mul_div_unit_if.sv
// Operand/command/result bundle between the execute stage and the multiply/divide unit.
// The slave side is the unit itself; the master side is the controller or testbench.
interface mul_div_unit_if;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [2:0]  MDCtrl;
    logic        start;
    logic        outSel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdOut;

    modport master (
        output srcA, srcB, MDCtrl, start, outSel,
        input  busy, HI, LO, mdOut
    );

    modport slave (
        input  srcA, srcB, MDCtrl, start, outSel,
        output busy, HI, LO, mdOut
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at the
// accept edge, parked in pending registers, and committed to HI/LO when the countdown expires.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  md
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;

    logic [63:0]        prod_s_s;
    logic [63:0]        prod_u_s;
    logic [31:0]        sdiv_q_s, sdiv_r_s;
    logic [31:0]        udiv_q_s, udiv_r_s;
    logic               div_by_zero_s;

    // Low 64 bits of a product are sign-agnostic once both operands are sign-extended.
    assign prod_s_s = {{32{md.srcA[31]}}, md.srcA} * {{32{md.srcB[31]}}, md.srcB};
    assign prod_u_s = {32'd0, md.srcA} * {32'd0, md.srcB};

    assign div_by_zero_s = (md.srcB == 32'd0);

    // Quotient/remainder; zero divisor and INT_MIN/-1 are steered away from the raw operators.
    always_comb begin
        logic signed [31:0] sa_v;
        logic signed [31:0] sb_v;
        logic [31:0]        ub_v;
        sa_v     = $signed(md.srcA);
        sb_v     = div_by_zero_s ? 32'sd1 : $signed(md.srcB);
        ub_v     = div_by_zero_s ? 32'd1 : md.srcB;
        sdiv_q_s = 32'd0;
        sdiv_r_s = 32'd0;
        if ((md.srcA == 32'h8000_0000) && (md.srcB == 32'hFFFF_FFFF)) begin
            sdiv_q_s = 32'h8000_0000;
            sdiv_r_s = 32'd0;
        end else begin
            sdiv_q_s = $unsigned(sa_v / sb_v);
            sdiv_r_s = $unsigned(sa_v % sb_v);
        end
        udiv_q_s = md.srcA / ub_v;
        udiv_r_s = md.srcA % ub_v;
    end

    // Next-state: command accept in idle, countdown and commit while busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (md.start) begin
                    case (md.MDCtrl)
                        OP_MULT: begin
                            pend_hi_d = prod_s_s[63:32];
                            pend_lo_d = prod_s_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_BUSY;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u_s[63:32];
                            pend_lo_d = prod_u_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_BUSY;
                        end
                        OP_DIV: begin
                            pend_hi_d = sdiv_r_s;
                            pend_lo_d = sdiv_q_s;
                            pend_wr_d = !div_by_zero_s;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_d = udiv_r_s;
                            pend_lo_d = udiv_q_s;
                            pend_wr_d = !div_by_zero_s;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_BUSY;
                        end
                        OP_MTHI: hi_d = md.srcA;
                        OP_MTLO: lo_d = md.srcA;
                        default: ;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign md.busy  = (state_q == ST_BUSY);
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;
    assign md.mdOut = md.outSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit with hand-computed results and
// hand-written sequences for busy-collision, back-to-back and async-reset corners.
module tb_mul_div_unit;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    mul_div_unit_if md_if();

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_if.start  = 1'b1;
        md_if.MDCtrl = ctrl;
        md_if.srcA   = a;
        md_if.srcB   = b;
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
        md_if.srcA  = 32'hDEAD_BEEF;
        md_if.srcB  = 32'h0BAD_F00D;
    endtask

    // Counts cycles with busy high after an accept; bounded so a stuck busy still ends.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (md_if.busy && cyc < 50) begin
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        pass_cnt  = 0;
        total_cnt = 0;

        //           ctrl  a             b             hi            lo            cyc
        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'h00000007, 32'h00000000, 32'h11111111, 32'h22222222, 10};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
        vecs[6]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[7]  = '{3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5};
        vecs[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'h11111111, 32'h22222222, 10};
        vecs[10] = '{3'd4, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF, 10};
        vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        reset        = 1'b1;
        md_if.start  = 1'b0;
        md_if.MDCtrl = 3'd0;
        md_if.srcA   = 32'd0;
        md_if.srcB   = 32'd0;
        md_if.outSel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, md_if.busy}, 32'd0);
        check("rst_hi", md_if.HI, 32'd0);
        check("rst_lo", md_if.LO, 32'd0);
        check("rst_mdout", md_if.mdOut, 32'd0);

        // MTHI then MTLO on consecutive edges
        issue(3'd5, 32'h12345678, 32'd0);
        check("mthi_busy", {31'd0, md_if.busy}, 32'd0);
        check("mthi_hi", md_if.HI, 32'h12345678);
        check("mthi_lo_kept", md_if.LO, 32'd0);
        issue(3'd6, 32'hCAFEBABE, 32'd0);
        check("mtlo_busy", {31'd0, md_if.busy}, 32'd0);
        check("mtlo_lo", md_if.LO, 32'hCAFEBABE);
        check("mtlo_hi_kept", md_if.HI, 32'h12345678);
        md_if.outSel = 1'b1;
        #1;
        check("mdout_hi", md_if.mdOut, 32'h12345678);
        md_if.outSel = 1'b0;
        #1;
        check("mdout_lo", md_if.mdOut, 32'hCAFEBABE);

        issue(3'd0, 32'h55555555, 32'h1);
        issue(3'd7, 32'h66666666, 32'h1);
        check("nop_busy", {31'd0, md_if.busy}, 32'd0);
        check("nop_hi", md_if.HI, 32'h12345678);
        check("nop_lo", md_if.LO, 32'hCAFEBABE);

        for (int i = 0; i < 12; i++) begin
            issue(3'd5, 32'h11111111, 32'd0);
            issue(3'd6, 32'h22222222, 32'd0);
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), {31'd0, md_if.busy}, 32'd1);
            check($sformatf("v%0d_hold_hi", i), md_if.HI, 32'h11111111);
            wait_done(cyc);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
            check($sformatf("v%0d_hi", i), md_if.HI, vecs[i].hi);
            check($sformatf("v%0d_lo", i), md_if.LO, vecs[i].lo);
        end

        // DIV with MTLO while busy, MULT on completion edge ignored, accepted one edge later
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd6, 32'd0, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 3) begin
                md_if.start = 1'b1; md_if.MDCtrl = 3'd6; md_if.srcA = 32'h55555555;
            end else if (j == 10) begin
                md_if.start = 1'b1; md_if.MDCtrl = 3'd1; md_if.srcA = 32'd3; md_if.srcB = 32'd4;
            end else begin
                md_if.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (j == 4) check("coll_lo_hold", md_if.LO, 32'd0);
        end
        check("coll_done_busy", {31'd0, md_if.busy}, 32'd0);
        check("coll_lo_quot", md_if.LO, 32'd14);
        check("coll_hi_rem", md_if.HI, 32'd2);
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
        check("b2b_accept", {31'd0, md_if.busy}, 32'd1);
        wait_done(cyc);
        check("b2b_cycles", cyc, 32'd5);
        check("b2b_lo", md_if.LO, 32'd12);
        check("b2b_hi", md_if.HI, 32'd0);

        // Async reset mid-cycle during MULT; no late write afterwards
        issue(3'd5, 32'hAAAAAAAA, 32'd0);
        issue(3'd6, 32'hBBBBBBBB, 32'd0);
        issue(3'd1, 32'd6, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, md_if.busy}, 32'd0);
        check("arst_hi", md_if.HI, 32'd0);
        check("arst_lo", md_if.LO, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold_hi = 32'd0;
        hold_lo = 32'd0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            hold_hi = hold_hi | md_if.HI;
            hold_lo = hold_lo | md_if.LO | {31'd0, md_if.busy};
        end
        check("post_rst_hi", hold_hi, 32'd0);
        check("post_rst_lo_busy", hold_lo, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
